// File: rtl/pipe_adder_if.sv
// pipe_adder_if: operand/result handshake bundle for pipe_adder.
// Optional signal: ovf, present only when PIPE_ADDER_OVF_EN is defined.
// Handshake: an operand set moves in on a cycle with in_valid && in_ready,
// a result moves out on a cycle with out_valid && out_ready; a producer
// holds its payload stable while valid is high and ready is low.
interface pipe_adder_if #(
    parameter int N = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         Ci;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] S;
    logic         Co;
`ifdef PIPE_ADDER_OVF_EN
    logic         ovf;

    modport master (
        output in_valid, A, B, Ci, sub, out_ready,
        input  in_ready, out_valid, S, Co, ovf
    );

    modport slave (
        input  in_valid, A, B, Ci, sub, out_ready,
        output in_ready, out_valid, S, Co, ovf
    );
`else
    modport master (
        output in_valid, A, B, Ci, sub, out_ready,
        input  in_ready, out_valid, S, Co
    );

    modport slave (
        input  in_valid, A, B, Ci, sub, out_ready,
        output in_ready, out_valid, S, Co
    );
`endif
endinterface

// File: rtl/pipe_adder.sv
// pipe_adder: skewed ripple-carry adder/subtractor, STAGES slices of N/STAGES bits.
// Stage k adds slice k and forwards its carry, the finished low sum bits and
// the not-yet-added operand bits to stage k+1. Every stage advances together
// on adv, so a full pipeline stalls as a whole when the consumer is not ready.
// Optional feature: define PIPE_ADDER_OVF_EN to get the signed overflow flag bus.ovf.
module pipe_adder #(
    parameter int N      = 16,
    parameter int STAGES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    pipe_adder_if.slave bus
);
    localparam int W = N / STAGES;

    // The whole pipe moves when the output slot is empty or being consumed.
    logic adv;
    assign adv          = bus.out_ready || !bus.out_valid;
    assign bus.in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * W;
        localparam int HI = (k + 1) * W;

        logic [N-LO-1:0] a_in;
        logic [N-LO-1:0] b_in;
        logic            c_in;
        logic            v_in;
        logic [W:0]      slice;
        logic [HI-1:0]   s_n;
        logic            v_q;
        logic            c_q;
        logic [HI-1:0]   s_q;

        if (k == 0) begin : g_head
            // Subtraction is A + ~B + 1; Ci only matters for addition.
            assign a_in = bus.A;
            assign b_in = bus.sub ? ~bus.B : bus.B;
            assign c_in = bus.sub | bus.Ci;
            assign v_in = bus.in_valid;
            assign s_n  = slice[W-1:0];
        end else begin : g_body
            assign a_in = g_stage[k-1].g_fwd.a_q;
            assign b_in = g_stage[k-1].g_fwd.b_q;
            assign c_in = g_stage[k-1].c_q;
            assign v_in = g_stage[k-1].v_q;
            assign s_n  = {slice[W-1:0], g_stage[k-1].s_q};
        end

        assign slice = {1'b0, a_in[W-1:0]} + {1'b0, b_in[W-1:0]} + {{W{1'b0}}, c_in};

        // Slot valid, slice carry and accumulated low sum bits.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (adv) begin
                v_q <= v_in;
                c_q <= slice[W];
                s_q <= s_n;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [N-HI-1:0] a_q;
            logic [N-HI-1:0] b_q;

            // Operand bits still waiting for a later slice.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_in[N-LO-1:W];
                    b_q <= b_in[N-LO-1:W];
                end
            end
        end

`ifdef PIPE_ADDER_OVF_EN
        if (k == STAGES - 1) begin : g_last
            logic ovf_q;

            // Signed overflow: carry into bit N-1 (a^b^sum at the MSB) xor carry out.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    ovf_q <= a_in[W-1] ^ b_in[W-1] ^ slice[W-1] ^ slice[W];
                end
            end
        end
`endif
    end

    assign bus.out_valid = g_stage[STAGES-1].v_q;
    assign bus.S         = g_stage[STAGES-1].s_q;
    assign bus.Co        = g_stage[STAGES-1].c_q;
`ifdef PIPE_ADDER_OVF_EN
    assign bus.ovf       = g_stage[STAGES-1].g_last.ovf_q;
`endif
endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: directed and soak stimulus for pipe_adder with a result model.
// Honors PIPE_ADDER_OVF_EN to also check the ovf output.
module tb_pipe_adder;
    localparam int N      = 16;
    localparam int STAGES = 4;
    localparam int L      = STAGES - 1;

    typedef struct packed {
        logic         v;
        logic [N-1:0] s;
        logic         co;
        logic         ovf;
    } slot_t;

    logic  clk;
    logic  rst_n;
    logic  cmp_en;
    logic  acc;
    int    n_checks = 0;
    int    n_pass   = 0;
    slot_t mdl [STAGES];
    logic  m_adv;

    pipe_adder_if #(.N(N)) bus ();

    pipe_adder #(.N(N), .STAGES(STAGES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Arithmetic meaning of one operand set, from plain integer math.
    function automatic slot_t ref_result(input logic v, input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic ci, input logic sb);
        slot_t  r;
        longint u;
        longint sres;
        longint sa;
        longint sbv;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        if (sb) begin
            u    = longint'(a) - longint'(b) + (longint'(1) << N);
            sres = sa - sbv;
        end else begin
            u    = longint'(a) + longint'(b) + longint'(ci);
            sres = sa + sbv + longint'(ci);
        end
        r.v   = v;
        r.s   = u[N-1:0];
        r.co  = u[N];
        r.ovf = (sres > (longint'(1) << (N-1)) - 1) || (sres < -(longint'(1) << (N-1)));
        return r;
    endfunction

    // Slot model: all slots shift together whenever the last slot is empty or taken.
    assign m_adv = bus.out_ready || !mdl[L].v;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) mdl[i] <= '0;
        end else if (m_adv) begin
            for (int i = STAGES - 1; i > 0; i--) mdl[i] <= mdl[i-1];
            mdl[0] <= ref_result(bus.in_valid, bus.A, bus.B, bus.Ci, bus.sub);
        end
    end

    // Every-cycle comparison of the DUT outputs against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("out_valid", {63'd0, bus.out_valid}, {63'd0, mdl[L].v});
            check("in_ready", {63'd0, bus.in_ready}, {63'd0, m_adv});
            if (mdl[L].v) begin
                check("S", 64'(bus.S), 64'(mdl[L].s));
                check("Co", {63'd0, bus.Co}, {63'd0, mdl[L].co});
`ifdef PIPE_ADDER_OVF_EN
                check("ovf", {63'd0, bus.ovf}, {63'd0, mdl[L].ovf});
`endif
            end
        end
    end

    // One operand set through an otherwise idle pipe; caller is just after a rising edge.
    task automatic directed(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                            input logic ci, input logic sb,
                            input logic [N-1:0] es, input logic eco, input logic eovf);
        bus.A = a; bus.B = b; bus.Ci = ci; bus.sub = sb; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        for (int i = 0; i < STAGES - 1; i++) begin
            @(negedge clk);
            check({name, "_early"}, {63'd0, bus.out_valid}, 64'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check({name, "_valid"}, {63'd0, bus.out_valid}, 64'd1);
        check({name, "_S"}, 64'(bus.S), 64'(es));
        check({name, "_Co"}, {63'd0, bus.Co}, {63'd0, eco});
`ifdef PIPE_ADDER_OVF_EN
        check({name, "_ovf"}, {63'd0, bus.ovf}, {63'd0, eovf});
`endif
        @(posedge clk); #1;
    endtask

    initial begin
        logic [N-1:0] bst_a [8];
        logic [N-1:0] bst_b [8];
        int first;
        int last;
        int cnt;
        int idx;

        bst_a = '{16'h0001, 16'hFFFF, 16'h8000, 16'h1234, 16'h7FFF, 16'h00F0, 16'hAAAA, 16'h0000};
        bst_b = '{16'h0002, 16'hFFFF, 16'h0001, 16'h4321, 16'h0001, 16'h0F10, 16'h5555, 16'hFFFF};

        rst_n = 1'b0; cmp_en = 1'b0; acc = 1'b0;
        bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.Ci = 1'b0; bus.sub = 1'b0;
        bus.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_S", 64'(bus.S), 64'd0);
        check("rst_Co", {63'd0, bus.Co}, 64'd0);
        check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
`ifdef PIPE_ADDER_OVF_EN
        check("rst_ovf", {63'd0, bus.ovf}, 64'd0);
`endif
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        // First transfer on the first rising edge after release.
        directed("wrap",     16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        directed("sub_neg",  16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        directed("sub_ovf",  16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1);
        directed("add_ci",   16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0);
        directed("add_ovf",  16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        directed("ripple",   16'h0FFF, 16'h0001, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0);
        directed("sub_ci_x", 16'h0010, 16'h0010, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);

        // Back-to-back burst of 8.
        first = -1; last = -1; cnt = 0;
        for (int c = 0; c < 8 + STAGES + 2; c++) begin
            if (c < 8) begin
                bus.A = bst_a[c]; bus.B = bst_b[c]; bus.Ci = c[0]; bus.sub = c[1];
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            if (bus.out_valid) begin
                cnt++;
                if (first < 0) first = c;
                last = c;
            end
            @(posedge clk); #1;
        end
        check("burst_count", 64'(cnt), 64'd8);
        check("burst_first", 64'(first), 64'(STAGES));
        check("burst_span", 64'(last - first), 64'd7);

        // Stall with a full pipe, then drain.
        bus.out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < STAGES + 6; c++) begin
            bus.A = 16'h1111 * 16'(idx + 1); bus.B = 16'h2222; bus.Ci = 1'b0; bus.sub = 1'b0;
            bus.in_valid = 1'b1;
            @(negedge clk);
            acc = bus.in_ready;
            if (c >= STAGES) begin
                check("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
                check("stall_S", 64'(bus.S), 64'h3333);
            end
            @(posedge clk); #1;
            if (acc) idx++;
        end
        check("stall_accepted", 64'(idx), 64'(STAGES));
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        cnt = 0;
        for (int c = 0; c < STAGES + 4; c++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) cnt++;
            @(posedge clk); #1;
        end
        check("drain_count", 64'(cnt), 64'(STAGES));

        // Reset with results in flight.
        for (int c = 0; c < 6; c++) begin
            bus.A = 16'h0100 * 16'(c + 1); bus.B = 16'h0003; bus.Ci = 1'b0; bus.sub = 1'b0;
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        check("pre_rst_valid", {63'd0, bus.out_valid}, 64'd1);
        check("pre_rst_S", 64'(bus.S), 64'h0303);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {63'd0, bus.out_valid}, 64'd0);
        check("mid_rst_S", 64'(bus.S), 64'd0);
        check("mid_rst_Co", {63'd0, bus.Co}, 64'd0);
        check("mid_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.out_valid) cnt++;
        end
        check("post_rst_stale", 64'(cnt), 64'd0);
        @(posedge clk); #1;

        // Random valid/ready soak.
        acc = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!bus.in_valid || acc) begin
                bus.A   = N'($urandom);
                bus.B   = N'($urandom);
                bus.Ci  = 1'($urandom_range(0, 1));
                bus.sub = 1'($urandom_range(0, 1));
                bus.in_valid = ($urandom_range(0, 3) != 0);
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (STAGES + 2) @(posedge clk);
        @(negedge clk);
        check("soak_empty", {63'd0, bus.out_valid}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
